serial2mem: RTL and testbench
=============================

# serial2mem

Receive-side counterpart of the sniffer's serial dump path. It takes bytes from a UART receiver and reassembles 48-bit records sent MSB-first as six data bytes plus a 0x0a trailer. Each complete record is written into a write-side FIFO. Malformed, stalled or unstorable records are dropped and counted, and the block resynchronises on the trailer byte.

## Interface
- TIMEOUT_CYCLES, default 50000: idle clk cycles allowed between bytes of one record; must be ≥ 2 and < 65536.
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- uart_valid  in  1  one-cycle strobe; uart_data holds a new received byte
- uart_data  in  8  received byte, valid only while uart_valid = 1
- write_full  in  1  FIFO full; high means no write is accepted
- write_clk_enable  out  1  one-cycle FIFO write strobe
- write_data  out  48  assembled record; stable while write_clk_enable = 1
- frame_error  out  1  one-cycle pulse when a record is discarded for bad trailer or timeout
- overflow  out  1  one-cycle pulse when a good record is discarded because write_full = 1
- drop_count  out  8  saturating count of discarded records (frame errors plus overflows)

## Operation
- Internal state:
  - 48-bit shift register shift
  - 3-bit byte counter cnt (0..5)
  - 16-bit idle counter idle
  - FSM {COLLECT, TRAILER, SYNC}
- Reset:
  - state = COLLECT, cnt = 0, idle = 0, shift = 0
  - all outputs 0, write_data = 48'h0
- COLLECT, on uart_valid:
  - shift <= {shift[39:0], uart_data}; the first byte ends up in bits [47:40].
  - If cnt = 5: cnt <= 0 and go to TRAILER. Otherwise cnt <= cnt + 1.
  - The byte value is not checked; 0x0a is legal data here.
- TRAILER, on uart_valid:
  - Byte = 0x0a and write_full = 0: write_data <= shift, write_clk_enable <= 1, go to COLLECT.
  - Byte = 0x0a and write_full = 1: overflow <= 1, drop_count increments, go to COLLECT, no write.
  - Any other byte: frame_error <= 1, drop_count increments, go to SYNC.
- SYNC, on uart_valid:
  - Byte = 0x0a: go to COLLECT with cnt = 0.
  - Any other byte: discard it and stay in SYNC.
  - No timeout applies in SYNC.
- Timeout:
  - A record is partial when state = COLLECT with cnt > 0, or state = TRAILER.
  - While a record is partial and uart_valid = 0, idle increments each cycle. idle clears to 0 on any uart_valid and on every state change.
  - When idle = TIMEOUT_CYCLES − 1 the record is discarded: frame_error <= 1, drop_count increments, state = COLLECT, cnt = 0, idle = 0.
  - A uart_valid in the same cycle as the timeout wins: the byte is processed normally and the timeout is suppressed.
- drop_count saturates at 8'hFF and never wraps.
- write_data holds its last written value between writes.
- write_full is sampled only in the cycle the trailer is accepted. No write is ever retried.

## Timing
- Trailer accepted at clk edge N (uart_valid = 1 in the cycle before N):
  - write_clk_enable, overflow or frame_error is high for exactly cycle N → N+1.
  - It deasserts at edge N+1.
  - Latency from trailer strobe to write strobe is 1 cycle.
- Back-to-back uart_valid on consecutive cycles is accepted in every state. A new byte in the same cycle as a write pulse is processed normally.
- At most one of write_clk_enable, overflow and frame_error is high in any cycle.
- Asserting reset mid-record aborts it immediately:
  - all outputs 0, partial data lost
  - the drop is not counted
- After reset release, the first uart_valid is treated as data byte 0.

## Test plan
- Good record: bytes DE AD BE EF 01 02 0A, write_full = 0.
  - write_data = 48'hDEADBEEF0102.
  - Exactly one write_clk_enable pulse, 1 cycle after the 0A strobe.
  - drop_count = 0.
- Bad trailer then resync: 11 22 33 44 55 66 77, then 0A, then AA BB CC DD EE FF 0A.
  - One frame_error pulse after 77; drop_count = 1; no write.
  - The 0A only resyncs and causes no write.
  - Then one write with write_data = 48'hAABBCCDDEEFF.
- Overflow: record 01..06 0A with write_full = 1 at the trailer.
  - One overflow pulse, no write, drop_count = 1.
  - Next record 10..15 0A with write_full = 0 writes 48'h101112131415.
- Timeout: TIMEOUT_CYCLES = 100; send 3 bytes, then idle 100 cycles.
  - frame_error pulses once; drop_count = 1.
  - Following record 0A 0A 0A 0A 0A 0A 0A writes 48'h0A0A0A0A0A0A.
  - A gap of 98 idle cycles mid-record produces no timeout.
- Reset mid-record: 4 bytes, then reset pulse.
  - All outputs read 0 during and after reset.
  - Next record 01..06 0A writes 48'h010203040506.
- Saturation: 260 records with bad trailer, each followed by a resync 0A.
  - drop_count ends at 8'hFF and does not wrap.

Source files
------------

// File: rtl/serial2mem.sv
// ============================================================================
// Module      : serial2mem
// Description : Reassembles 48-bit records from a UART byte stream (six data
//               bytes MSB-first plus a 0x0a trailer) and pushes each complete
//               record into a write-side FIFO. Malformed, stalled or
//               unstorable records are dropped and counted; the receiver
//               resynchronises on the trailer byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial2mem #(
  // Idle clk cycles tolerated between bytes of one record (2 .. 65535)
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_valid,
  input  logic [7:0]  uart_data,
  input  logic        write_full,
  output logic        write_clk_enable,
  output logic [47:0] write_data,
  output logic        frame_error,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,   // gathering the six data bytes
    TRAILER = 2'd1,   // all data in, waiting for the 0x0a trailer
    SYNC    = 2'd2    // after a bad trailer, discard until a 0x0a is seen
  } state_t;

  localparam logic [7:0]  TRAILER_BYTE = 8'h0a;
  localparam logic [2:0]  LAST_BYTE    = 3'd5;
  // The timeout fires in the cycle the idle counter reaches this value
  localparam logic [15:0] IDLE_LIMIT   = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [47:0] shift;
  logic [2:0]  cnt;
  logic [15:0] idle;

  // A record is in flight once its first data byte arrived; only then can it
  // stall. SYNC is deliberately excluded so a silent line never times out.
  logic       partial;
  logic [7:0] drop_next;

  // Partial-record detection and saturating drop increment
  always_comb begin
    partial   = ((state == COLLECT) && (cnt != 3'd0)) || (state == TRAILER);
    drop_next = (drop_count == 8'hFF) ? 8'hFF : (drop_count + 8'd1);
  end

  // Record assembly FSM with registered status/strobe outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= COLLECT;
      shift            <= 48'h0;
      cnt              <= 3'd0;
      idle             <= 16'd0;
      write_clk_enable <= 1'b0;
      write_data       <= 48'h0;
      frame_error      <= 1'b0;
      overflow         <= 1'b0;
      drop_count       <= 8'h00;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below
      write_clk_enable <= 1'b0;
      frame_error      <= 1'b0;
      overflow         <= 1'b0;

      if (uart_valid) begin
        // Any received byte restarts the stall timer; this also lets a byte
        // arriving in the timeout cycle win over the timeout.
        idle <= 16'd0;
        case (state)
          COLLECT: begin
            // Data bytes are taken as-is; 0x0a is legal payload here
            shift <= {shift[39:0], uart_data};
            if (cnt == LAST_BYTE) begin
              cnt   <= 3'd0;
              state <= TRAILER;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end

          TRAILER: begin
            if (uart_data == TRAILER_BYTE) begin
              state <= COLLECT;
              // FIFO space is sampled only here; a refused record is lost
              if (!write_full) begin
                write_data       <= shift;
                write_clk_enable <= 1'b1;
              end else begin
                overflow   <= 1'b1;
                drop_count <= drop_next;
              end
            end else begin
              frame_error <= 1'b1;
              drop_count  <= drop_next;
              state       <= SYNC;
            end
          end

          SYNC: begin
            // Everything up to and including the next trailer is discarded
            if (uart_data == TRAILER_BYTE) begin
              state <= COLLECT;
              cnt   <= 3'd0;
            end
          end

          default: begin
            state <= COLLECT;
            cnt   <= 3'd0;
          end
        endcase
      end else if (partial) begin
        if (idle == IDLE_LIMIT) begin
          // Stalled record: abandon it and start over at byte 0
          frame_error <= 1'b1;
          drop_count  <= drop_next;
          state       <= COLLECT;
          cnt         <= 3'd0;
          idle        <= 16'd0;
        end else begin
          idle <= idle + 16'd1;
        end
      end else begin
        idle <= 16'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial2mem.sv
// ============================================================================
// Module      : tb_serial2mem
// Description : Self-checking bench for serial2mem. A byte-stream reference
//               model (queue of collected bytes, sync flag, idle-gap length)
//               predicts writes, drops and pulse counts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial2mem;

  localparam int T = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_valid = 1'b0;
  logic [7:0]  uart_data = 8'h00;
  logic        write_full = 1'b0;
  logic        write_clk_enable;
  logic [47:0] write_data;
  logic        frame_error;
  logic        overflow;
  logic [7:0]  drop_count;

  serial2mem #(.TIMEOUT_CYCLES(T)) dut (
    .clk              (clk),
    .reset            (reset),
    .uart_valid       (uart_valid),
    .uart_data        (uart_data),
    .write_full       (write_full),
    .write_clk_enable (write_clk_enable),
    .write_data       (write_data),
    .frame_error      (frame_error),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Passive observation of the DUT outputs
  int cyc = 0;
  int n_wr = 0, n_fe = 0, n_ov = 0, n_multi = 0;
  int wr_cyc = -1, fe_cyc = -1, ov_cyc = -1;
  int last_strobe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      if (write_clk_enable) begin n_wr <= n_wr + 1; wr_cyc <= cyc; end
      if (frame_error)      begin n_fe <= n_fe + 1; fe_cyc <= cyc; end
      if (overflow)         begin n_ov <= n_ov + 1; ov_cyc <= cyc; end
      if ((32'(write_clk_enable) + 32'(frame_error) + 32'(overflow)) > 1)
        n_multi <= n_multi + 1;
    end
  end

  // ---------------- reference model (byte-stream level) ----------------
  logic [7:0]  m_rec[$];
  bit          m_sync = 0;
  int          m_gap = 0;
  int          m_wr = 0, m_fe = 0, m_ov = 0, m_drops = 0;
  logic [47:0] m_data = 48'h0;

  function automatic void m_drop();
    if (m_drops < 255) m_drops++;
  endfunction

  function automatic void m_reset();
    m_rec.delete();
    m_sync  = 0;
    m_gap   = 0;
    m_drops = 0;
    m_data  = 48'h0;
  endfunction

  // n silent cycles: a record in flight is lost once the silence reaches T
  function automatic void m_idle(input int n);
    m_gap += n;
    if (!m_sync && m_rec.size() > 0 && m_gap >= T) begin
      m_fe++;
      m_drop();
      m_rec.delete();
    end
  endfunction

  function automatic void m_byte(input logic [7:0] b, input logic full);
    m_gap = 0;
    if (m_sync) begin
      if (b == 8'h0a) m_sync = 0;
    end else if (m_rec.size() < 6) begin
      m_rec.push_back(b);
    end else begin
      if (b == 8'h0a) begin
        if (full) begin m_ov++; m_drop(); end
        else begin
          m_wr++;
          m_data = {m_rec[0], m_rec[1], m_rec[2], m_rec[3], m_rec[4], m_rec[5]};
        end
      end else begin
        m_fe++;
        m_drop();
        m_sync = 1;
      end
      m_rec.delete();
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    m_idle(n);
  endtask

  task automatic send(input logic [7:0] b, input int gap, input logic full);
    if (gap > 0) idle(gap);
    uart_valid  = 1'b1;
    uart_data   = b;
    write_full  = full;
    last_strobe = cyc;
    @(negedge clk);
    uart_valid = 1'b0;
    uart_data  = 8'($urandom);
    write_full = 1'($urandom);
    m_byte(b, full);
  endtask

  task automatic send_record(input logic [47:0] d, input logic [7:0] trl,
                             input int gap, input logic full);
    for (int i = 0; i < 6; i++) send(d[47-8*i -: 8], gap, 1'b0);
    send(trl, gap, full);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({write_clk_enable, frame_error, overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000", {write_clk_enable, frame_error, overflow});
    end
    checks++;
    if (write_data !== 48'h0) begin
      errors++; $display("FAIL reset_write_data: got %h expected 0", write_data);
    end
    checks++;
    if (drop_count !== 8'h00) begin
      errors++; $display("FAIL reset_drop_count: got %h expected 00", drop_count);
    end
    reset = 1'b1;
    m_reset();
    idle(2);
  endtask

  task automatic test_good_record();
    int w0 = n_wr;
    send_record(48'hDEADBEEF0102, 8'h0a, 0, 1'b0);
    idle(3); #1;
    checks++;
    if (n_wr - w0 !== 1) begin
      errors++; $display("FAIL good_write_count: got %0d expected 1", n_wr - w0);
    end
    checks++;
    if (write_data !== 48'hDEADBEEF0102) begin
      errors++; $display("FAIL good_write_data: got %h expected deadbeef0102", write_data);
    end
    checks++;
    if (wr_cyc !== last_strobe + 1) begin
      errors++; $display("FAIL good_write_latency: got cycle %0d expected %0d", wr_cyc, last_strobe + 1);
    end
    checks++;
    if (drop_count !== 8'h00) begin
      errors++; $display("FAIL good_drop_count: got %0d expected 0", drop_count);
    end
  endtask

  task automatic test_bad_trailer_resync();
    int w0 = n_wr, f0 = n_fe;
    send_record(48'h112233445566, 8'h77, 0, 1'b0);
    idle(2); #1;
    checks++;
    if (n_fe - f0 !== 1 || fe_cyc !== last_strobe + 1) begin
      errors++; $display("FAIL bad_trailer_frame_error: got %0d pulses at %0d expected 1 at %0d", n_fe - f0, fe_cyc, last_strobe + 1);
    end
    send(8'h0a, 0, 1'b0);
    idle(2); #1;
    checks++;
    if (n_wr - w0 !== 0) begin
      errors++; $display("FAIL resync_no_write: got %0d writes expected 0", n_wr - w0);
    end
    checks++;
    if (drop_count !== 8'd1) begin
      errors++; $display("FAIL bad_trailer_drop_count: got %0d expected 1", drop_count);
    end
    send_record(48'hAABBCCDDEEFF, 8'h0a, 0, 1'b0);
    idle(2); #1;
    checks++;
    if (n_wr - w0 !== 1 || write_data !== 48'hAABBCCDDEEFF) begin
      errors++; $display("FAIL resync_write: got %0d writes data %h expected 1 aabbccddeeff", n_wr - w0, write_data);
    end
  endtask

  task automatic test_overflow();
    int w0 = n_wr, o0 = n_ov;
    int d0 = int'(drop_count);
    send_record(48'h010203040506, 8'h0a, 0, 1'b1);
    idle(2); #1;
    checks++;
    if (n_ov - o0 !== 1 || ov_cyc !== last_strobe + 1) begin
      errors++; $display("FAIL overflow_pulse: got %0d pulses at %0d expected 1 at %0d", n_ov - o0, ov_cyc, last_strobe + 1);
    end
    checks++;
    if (n_wr - w0 !== 0 || int'(drop_count) !== d0 + 1) begin
      errors++; $display("FAIL overflow_drop: got writes %0d drops %0d expected 0 and %0d", n_wr - w0, drop_count, d0 + 1);
    end
    send_record(48'h101112131415, 8'h0a, 0, 1'b0);
    idle(2); #1;
    checks++;
    if (n_wr - w0 !== 1 || write_data !== 48'h101112131415) begin
      errors++; $display("FAIL overflow_next_write: got %0d writes data %h expected 1 101112131415", n_wr - w0, write_data);
    end
  endtask

  task automatic test_timeout();
    int f0 = n_fe, w0 = n_wr;
    int d0 = int'(drop_count);
    int s;
    send(8'h01, 0, 1'b0); send(8'h02, 0, 1'b0); send(8'h03, 0, 1'b0);
    s = last_strobe;
    idle(T + 2); #1;
    checks++;
    if (n_fe - f0 !== 1 || fe_cyc !== s + T + 1) begin
      errors++; $display("FAIL timeout_pulse: got %0d pulses at %0d expected 1 at %0d", n_fe - f0, fe_cyc, s + T + 1);
    end
    checks++;
    if (int'(drop_count) !== d0 + 1) begin
      errors++; $display("FAIL timeout_drop_count: got %0d expected %0d", drop_count, d0 + 1);
    end
    send_record(48'h0A0A0A0A0A0A, 8'h0a, 0, 1'b0);
    idle(2); #1;
    checks++;
    if (n_wr - w0 !== 1 || write_data !== 48'h0A0A0A0A0A0A) begin
      errors++; $display("FAIL timeout_next_write: got %0d writes data %h expected 1 0a0a0a0a0a0a", n_wr - w0, write_data);
    end
    // gaps of T-2 and T-1 idle cycles mid-record must not time out
    for (int i = 0; i < 6; i++) send(8'h20 + 8'(i), (i == 3) ? T - 2 : 0, 1'b0);
    send(8'h0a, T - 1, 1'b0);
    idle(2); #1;
    checks++;
    if (n_fe - f0 !== 1 || n_wr - w0 !== 2 || write_data !== 48'h202122232425) begin
      errors++; $display("FAIL near_timeout_gap: got fe %0d writes %0d data %h expected 1 2 202122232425", n_fe - f0, n_wr - w0, write_data);
    end
  endtask

  task automatic test_reset_mid_record();
    int w0 = n_wr;
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 0, 1'b0);
    #2 reset = 1'b0;
    m_reset();
    #1;
    checks++;
    if ({write_clk_enable, frame_error, overflow} !== 3'b000 || write_data !== 48'h0 || drop_count !== 8'h00) begin
      errors++; $display("FAIL reset_async_outputs: got %b %h %h expected all zero", {write_clk_enable, frame_error, overflow}, write_data, drop_count);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({write_clk_enable, frame_error, overflow} !== 3'b000 || write_data !== 48'h0 || drop_count !== 8'h00) begin
        errors++; $display("FAIL reset_held_outputs: got %b %h %h expected all zero", {write_clk_enable, frame_error, overflow}, write_data, drop_count);
      end
    end
    reset = 1'b1;
    idle(3); #1;
    checks++;
    if ({write_clk_enable, frame_error, overflow} !== 3'b000 || write_data !== 48'h0 || drop_count !== 8'h00 || n_wr !== w0) begin
      errors++; $display("FAIL reset_release_outputs: got %b %h %h expected all zero", {write_clk_enable, frame_error, overflow}, write_data, drop_count);
    end
    send_record(48'h010203040506, 8'h0a, 0, 1'b0);
    idle(2); #1;
    checks++;
    if (n_wr - w0 !== 1 || write_data !== 48'h010203040506) begin
      errors++; $display("FAIL reset_next_write: got %0d writes data %h expected 1 010203040506", n_wr - w0, write_data);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = n_wr, f0 = n_fe;
    send_record(48'h313233343536, 8'h0a, 0, 1'b0);
    send_record(48'h414243444546, 8'h0a, 0, 1'b0);
    send_record(48'h515253545556, 8'h99, 0, 1'b0);
    send(8'h0a, 0, 1'b0);
    send_record(48'h616263646566, 8'h0a, 0, 1'b0);
    idle(2); #1;
    checks++;
    if (n_wr - w0 !== 3 || n_fe - f0 !== 1) begin
      errors++; $display("FAIL b2b_counts: got writes %0d fe %0d expected 3 1", n_wr - w0, n_fe - f0);
    end
    checks++;
    if (write_data !== m_data || wr_cyc !== last_strobe + 1) begin
      errors++; $display("FAIL b2b_last_write: got %h at %0d expected %h at %0d", write_data, wr_cyc, m_data, last_strobe + 1);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      logic [47:0] d;
      logic [7:0]  trl;
      for (int i = 0; i < 6; i++) begin
        logic [7:0] b = ($urandom_range(0, 9) == 0) ? 8'h0a : 8'($urandom);
        int g = ($urandom_range(0, 14) == 0) ? int'($urandom_range(T - 3, T + 2)) : int'($urandom_range(0, 2));
        send(b, g, 1'b0);
      end
      trl = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h0a;
      send(trl, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
      if (m_sync) begin
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
          d = 48'($urandom);
          send(d[7:0], 0, 1'b0);
        end
        send(8'h0a, int'($urandom_range(0, 1)), 1'b0);
      end
      idle(2); #1;
      checks++;
      if (n_wr !== m_wr || n_fe !== m_fe || n_ov !== m_ov) begin
        errors++; $display("FAIL random_counts[%0d]: got wr %0d fe %0d ov %0d expected %0d %0d %0d", r, n_wr, n_fe, n_ov, m_wr, m_fe, m_ov);
      end
      checks++;
      if (int'(drop_count) !== m_drops || write_data !== m_data) begin
        errors++; $display("FAIL random_state[%0d]: got drops %0d data %h expected %0d %h", r, drop_count, write_data, m_drops, m_data);
      end
    end
    checks++;
    if (n_multi !== 0) begin
      errors++; $display("FAIL exclusive_strobes: got %0d overlapping cycles expected 0", n_multi);
    end
  endtask

  task automatic test_saturation();
    int f0;
    pulse_reset();
    f0 = n_fe;
    for (int r = 0; r < 260; r++) begin
      send_record(48'($urandom), 8'h55, 0, 1'b0);
      send(8'h0a, 0, 1'b0);
      if (r == 254) begin
        idle(1); #1;
        checks++;
        if (drop_count !== 8'hFF) begin
          errors++; $display("FAIL saturation_reach: got %0d expected 255", drop_count);
        end
      end
    end
    idle(2); #1;
    checks++;
    if (drop_count !== 8'hFF || int'(drop_count) !== m_drops) begin
      errors++; $display("FAIL saturation_hold: got %0d expected 255", drop_count);
    end
    checks++;
    if (n_fe - f0 !== 260) begin
      errors++; $display("FAIL saturation_pulses: got %0d expected 260", n_fe - f0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_record();
    test_bad_trailer_resync();
    test_overflow();
    test_timeout();
    test_reset_mid_record();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
